// File: rtl/aes_gcm_tag_gen.sv
// ---------------------------------------------------------------------------
// aes_gcm_tag_gen
// Finalisation stage that sits after the GCM phase controller.
//   * Lengths job: in phase 3, sends {len_aad_bits, len_pld_bits} to GHASH,
//     then captures the final GHASH accumulator as tag_pre_xor.
//   * Mask job: on tagmask_start, sends J0 to the AES core and captures
//     E_K(J0) as tagmask.
// Both results are held as levels until the next session start or reset.
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   start                        : session level; its rising edge opens a session
//   phase[2:0]                   : controller phase, 3 = lengths phase
//   len_aad_bits, len_pld_bits   : bit lengths, latched on the start edge
//   tagmask_start, j0            : tag-mask request and pre-counter block
//   gh_valid/gh_ready/gh_data    : length block handshake towards GHASH
//   ghash_state_valid/ghash_state: final GHASH accumulator pulse
//   aes_req_valid/ready/block    : AES request handshake
//   aes_rsp_valid/aes_rsp_block  : AES response pulse
//   lens_done, tag_pre_xor(_valid), tagmask(_valid): held results
//   err                          : sticky response-timeout flag
// ---------------------------------------------------------------------------
module aes_gcm_tag_gen #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   phase,
  input  logic [63:0]  len_aad_bits,
  input  logic [63:0]  len_pld_bits,
  input  logic         tagmask_start,
  input  logic [127:0] j0,
  output logic         gh_valid,
  input  logic         gh_ready,
  output logic [127:0] gh_data,
  input  logic         ghash_state_valid,
  input  logic [127:0] ghash_state,
  output logic         aes_req_valid,
  input  logic         aes_req_ready,
  output logic [127:0] aes_req_block,
  input  logic         aes_rsp_valid,
  input  logic [127:0] aes_rsp_block,
  output logic         lens_done,
  output logic [127:0] tag_pre_xor,
  output logic         tag_pre_xor_valid,
  output logic [127:0] tagmask,
  output logic         tagmask_valid,
  output logic         err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Last waiting cycle: a missing response here expires the wait.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_SEND = 2'd1,
    L_WAIT = 2'd2,
    L_DONE = 2'd3
  } lens_state_e;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_WAIT = 2'd2,
    M_DONE = 2'd3
  } mask_state_e;

  lens_state_e      l_state_r, l_next_s;
  mask_state_e      m_state_r, m_next_s;
  logic             start_q_r;
  logic             start_edge_s;
  logic             armed_r;
  logic [63:0]      len_aad_r, len_pld_r;
  logic [CNT_W-1:0] l_cnt_r, m_cnt_r;
  logic             l_expire_s, m_expire_s;
  logic             gh_valid_s, aes_req_valid_s;
  logic             gh_valid_r, aes_req_valid_r;
  logic [127:0]     aes_req_block_r;
  logic             lens_done_r;
  logic [127:0]     tag_pre_xor_r;
  logic [127:0]     tagmask_r;
  logic             tagmask_valid_r;
  logic             err_r;

  assign start_edge_s = start & ~start_q_r;
  // Expiry is only meaningful when no response arrives in the same cycle;
  // the next-state and err logic give the response priority.
  assign l_expire_s   = (l_state_r == L_WAIT) && (l_cnt_r == CNT_LAST);
  assign m_expire_s   = (m_state_r == M_WAIT) && (m_cnt_r == CNT_LAST);

  // State registers for both FSMs and the start-level delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_state_r <= L_IDLE;
      m_state_r <= M_IDLE;
      start_q_r <= 1'b0;
    end else begin
      l_state_r <= l_next_s;
      m_state_r <= m_next_s;
      start_q_r <= start;
    end
  end

  // Lens FSM next-state: one length block per armed session.
  always_comb begin
    l_next_s = l_state_r;
    if (start_edge_s) begin
      l_next_s = L_IDLE;
    end else begin
      case (l_state_r)
        L_IDLE: begin
          if ((phase == 3'd3) && armed_r) l_next_s = L_SEND;
          else                            l_next_s = L_IDLE;
        end
        L_SEND: begin
          if (gh_ready) l_next_s = L_WAIT;
          else          l_next_s = L_SEND;
        end
        L_WAIT: begin
          if (ghash_state_valid) l_next_s = L_DONE;
          else if (l_expire_s)   l_next_s = L_IDLE;
          else                   l_next_s = L_WAIT;
        end
        L_DONE:  l_next_s = L_DONE;
        default: l_next_s = L_IDLE;
      endcase
    end
  end

  // Mask FSM next-state: request E_K(J0), wait for the response.
  always_comb begin
    m_next_s = m_state_r;
    if (start_edge_s) begin
      m_next_s = M_IDLE;
    end else begin
      case (m_state_r)
        M_IDLE: begin
          if (tagmask_start) m_next_s = M_REQ;
          else               m_next_s = M_IDLE;
        end
        M_REQ: begin
          if (aes_req_ready) m_next_s = M_WAIT;
          else               m_next_s = M_REQ;
        end
        M_WAIT: begin
          if (aes_rsp_valid)   m_next_s = M_DONE;
          else if (m_expire_s) m_next_s = M_IDLE;
          else                 m_next_s = M_WAIT;
        end
        M_DONE:  m_next_s = M_DONE;
        default: m_next_s = M_IDLE;
      endcase
    end
  end

  // Output decode from next state so the valids leave a flop.
  always_comb begin
    gh_valid_s      = 1'b0;
    aes_req_valid_s = 1'b0;
    if (l_next_s == L_SEND) gh_valid_s = 1'b1;
    else                    gh_valid_s = 1'b0;
    if (m_next_s == M_REQ)  aes_req_valid_s = 1'b1;
    else                    aes_req_valid_s = 1'b0;
  end

  // Registered handshake valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      gh_valid_r      <= 1'b0;
      aes_req_valid_r <= 1'b0;
    end else begin
      gh_valid_r      <= gh_valid_s;
      aes_req_valid_r <= aes_req_valid_s;
    end
  end

  // Timeout counters: zero outside the wait state, so they restart on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_cnt_r <= '0;
      m_cnt_r <= '0;
    end else begin
      if (l_state_r == L_WAIT) l_cnt_r <= l_cnt_r + CNT_W'(1);
      else                     l_cnt_r <= '0;
      if (m_state_r == M_WAIT) m_cnt_r <= m_cnt_r + CNT_W'(1);
      else                     m_cnt_r <= '0;
    end
  end

  // Session data, captured results and sticky error; start edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r         <= 1'b0;
      len_aad_r       <= 64'd0;
      len_pld_r       <= 64'd0;
      aes_req_block_r <= 128'd0;
      lens_done_r     <= 1'b0;
      tag_pre_xor_r   <= 128'd0;
      tagmask_r       <= 128'd0;
      tagmask_valid_r <= 1'b0;
      err_r           <= 1'b0;
    end else if (start_edge_s) begin
      armed_r         <= 1'b1;
      len_aad_r       <= len_aad_bits;
      len_pld_r       <= len_pld_bits;
      lens_done_r     <= 1'b0;
      tag_pre_xor_r   <= 128'd0;
      tagmask_r       <= 128'd0;
      tagmask_valid_r <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      if ((l_state_r == L_IDLE) && (l_next_s == L_SEND)) begin
        armed_r <= 1'b0;
      end
      if ((l_state_r == L_WAIT) && ghash_state_valid) begin
        tag_pre_xor_r <= ghash_state;
        lens_done_r   <= 1'b1;
      end
      if ((m_state_r == M_IDLE) && tagmask_start) begin
        aes_req_block_r <= j0;
      end
      if ((m_state_r == M_WAIT) && aes_rsp_valid) begin
        tagmask_r       <= aes_rsp_block;
        tagmask_valid_r <= 1'b1;
      end
      if ((l_expire_s && !ghash_state_valid) || (m_expire_s && !aes_rsp_valid)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign gh_valid          = gh_valid_r;
  assign gh_data           = {len_aad_r, len_pld_r};
  assign aes_req_valid     = aes_req_valid_r;
  assign aes_req_block     = aes_req_block_r;
  assign lens_done         = lens_done_r;
  assign tag_pre_xor       = tag_pre_xor_r;
  assign tag_pre_xor_valid = lens_done_r;
  assign tagmask           = tagmask_r;
  assign tagmask_valid     = tagmask_valid_r;
  assign err               = err_r;

endmodule

// File: tb/tb_aes_gcm_tag_gen.sv
// ---------------------------------------------------------------------------
// tb_aes_gcm_tag_gen
// Directed bench for aes_gcm_tag_gen with TIMEOUT_CYCLES = 8. A transaction-
// level model tracks what each job should be showing; a compare process
// checks every output against it each cycle, and the directed sequence adds
// hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_aes_gcm_tag_gen;

  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst, start, tagmask_start, gh_ready, ghash_state_valid;
  logic         aes_req_ready, aes_rsp_valid;
  logic [2:0]   phase;
  logic [63:0]  len_aad_bits, len_pld_bits;
  logic [127:0] j0, ghash_state, aes_rsp_block;
  logic         gh_valid, aes_req_valid, lens_done, tag_pre_xor_valid;
  logic         tagmask_valid, err;
  logic [127:0] gh_data, aes_req_block, tag_pre_xor, tagmask;

  int n_vec = 0;
  int n_err = 0;

  aes_gcm_tag_gen #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .phase(phase),
    .len_aad_bits(len_aad_bits), .len_pld_bits(len_pld_bits),
    .tagmask_start(tagmask_start), .j0(j0),
    .gh_valid(gh_valid), .gh_ready(gh_ready), .gh_data(gh_data),
    .ghash_state_valid(ghash_state_valid), .ghash_state(ghash_state),
    .aes_req_valid(aes_req_valid), .aes_req_ready(aes_req_ready),
    .aes_req_block(aes_req_block),
    .aes_rsp_valid(aes_rsp_valid), .aes_rsp_block(aes_rsp_block),
    .lens_done(lens_done), .tag_pre_xor(tag_pre_xor),
    .tag_pre_xor_valid(tag_pre_xor_valid),
    .tagmask(tagmask), .tagmask_valid(tagmask_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- transaction-level model ----------------
  // Job progress: 0 = nothing pending, 1 = offering, 2 = awaiting response, 3 = finished.
  int           m_lens, m_mask, m_lwait, m_mwait;
  logic         m_init = 1'b0;
  logic         m_start_prev, m_armed, m_ldone, m_tmv, m_err;
  logic [63:0]  m_aad, m_pld;
  logic [127:0] m_tpx, m_tm, m_req;

  always @(posedge clk) begin : model
    int           lens, mask, lw, mw;
    logic         armed, ldone, tmv, er;
    logic [63:0]  aad, pld;
    logic [127:0] tpx, tm, req;
    lens = m_lens; mask = m_mask; lw = m_lwait; mw = m_mwait;
    armed = m_armed; ldone = m_ldone; tmv = m_tmv; er = m_err;
    aad = m_aad; pld = m_pld; tpx = m_tpx; tm = m_tm; req = m_req;
    if (rst) begin
      lens = 0; mask = 0; lw = 0; mw = 0;
      armed = 1'b0; ldone = 1'b0; tmv = 1'b0; er = 1'b0;
      aad = '0; pld = '0; tpx = '0; tm = '0; req = '0;
    end else if (start && !m_start_prev) begin
      lens = 0; mask = 0;
      armed = 1'b1; aad = len_aad_bits; pld = len_pld_bits;
      ldone = 1'b0; tpx = '0; tm = '0; tmv = 1'b0; er = 1'b0;
    end else begin
      if (lens == 0) begin
        if (phase == 3'd3 && armed) begin lens = 1; armed = 1'b0; end
      end else if (lens == 1) begin
        if (gh_ready) begin lens = 2; lw = 0; end
      end else if (lens == 2) begin
        if (ghash_state_valid) begin
          tpx = ghash_state; ldone = 1'b1; lens = 3;
        end else begin
          lw++;
          if (lw == T) begin er = 1'b1; lens = 0; end
        end
      end
      if (mask == 0) begin
        if (tagmask_start) begin mask = 1; req = j0; end
      end else if (mask == 1) begin
        if (aes_req_ready) begin mask = 2; mw = 0; end
      end else if (mask == 2) begin
        if (aes_rsp_valid) begin
          tm = aes_rsp_block; tmv = 1'b1; mask = 3;
        end else begin
          mw++;
          if (mw == T) begin er = 1'b1; mask = 0; end
        end
      end
    end
    m_lens <= lens; m_mask <= mask; m_lwait <= lw; m_mwait <= mw;
    m_armed <= armed; m_ldone <= ldone; m_tmv <= tmv; m_err <= er;
    m_aad <= aad; m_pld <= pld; m_tpx <= tpx; m_tm <= tm; m_req <= req;
    m_start_prev <= rst ? 1'b0 : start;
    m_init <= 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      check("gh_valid",          {127'd0, gh_valid},          {127'd0, (m_lens == 1)});
      check("gh_data",           gh_data,                     {m_aad, m_pld});
      check("aes_req_valid",     {127'd0, aes_req_valid},     {127'd0, (m_mask == 1)});
      check("aes_req_block",     aes_req_block,               m_req);
      check("lens_done",         {127'd0, lens_done},         {127'd0, m_ldone});
      check("tag_pre_xor_valid", {127'd0, tag_pre_xor_valid}, {127'd0, m_ldone});
      check("tag_pre_xor",       tag_pre_xor,                 m_tpx);
      check("tagmask_valid",     {127'd0, tagmask_valid},     {127'd0, m_tmv});
      check("tagmask",           tagmask,                     m_tm);
      check("err",               {127'd0, err},               {127'd0, m_err});
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [127:0] GH1  = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] J0A  = {96'hCAFEBABE_FACEB00C_12345678, 32'h00000001};
  localparam logic [127:0] RSPA = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] GH2  = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
  localparam logic [127:0] J0B  = {96'h000102030405060708090A0B, 32'h00000001};
  localparam logic [127:0] J0C  = {96'hFFEEDDCCBBAA998877665544, 32'h00000001};
  localparam logic [127:0] RSPC = 128'h89ABCDEF_01234567_76543210_FEDCBA98;

  initial begin
    rst = 1'b1; start = 1'b0; phase = 3'd0; tagmask_start = 1'b0;
    len_aad_bits = 64'd0; len_pld_bits = 64'd0; j0 = 128'd0;
    gh_ready = 1'b0; ghash_state_valid = 1'b0; ghash_state = 128'd0;
    aes_req_ready = 1'b0; aes_rsp_valid = 1'b0; aes_rsp_block = 128'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_gh_valid", {127'd0, gh_valid}, 128'd0);
    check("rst_err",      {127'd0, err},      128'd0);
    check("rst_lens_done",{127'd0, lens_done},128'd0);

    // Lengths sequence
    len_aad_bits = 64'h80; len_pld_bits = 64'h100; start = 1'b1;
    tick();
    phase = 3'd3;
    tick();
    check("len_gh_valid", {127'd0, gh_valid}, 128'd1);
    check("len_gh_data",  gh_data, 128'h0000000000000080_0000000000000100);
    len_aad_bits = 64'hFFFF; len_pld_bits = 64'hEEEE;
    repeat (3) begin
      tick();
      check("stall_gh_valid", {127'd0, gh_valid}, 128'd1);
      check("stall_gh_data",  gh_data, 128'h0000000000000080_0000000000000100);
    end
    gh_ready = 1'b1;
    tick();
    gh_ready = 1'b0;
    check("hs_gh_valid_low", {127'd0, gh_valid}, 128'd0);
    tick();
    ghash_state_valid = 1'b1; ghash_state = GH1;
    check("lens_done_pre", {127'd0, lens_done}, 128'd0);
    tick();
    ghash_state_valid = 1'b0;
    check("lens_done",   {127'd0, lens_done},         128'd1);
    check("tpx_valid",   {127'd0, tag_pre_xor_valid}, 128'd1);
    check("tag_pre_xor", tag_pre_xor, GH1);
    repeat (3) begin
      tick();
      check("single_shot", {127'd0, gh_valid}, 128'd0);
    end
    ghash_state_valid = 1'b1; ghash_state = 128'd7;
    tick();
    ghash_state_valid = 1'b0;
    check("stray_ghash", tag_pre_xor, GH1);

    // Mask sequence
    tagmask_start = 1'b1; j0 = J0A;
    tick();
    tagmask_start = 1'b0; j0 = 128'd0;
    check("req_valid", {127'd0, aes_req_valid}, 128'd1);
    check("req_block", aes_req_block, J0A);
    aes_req_ready = 1'b1;
    tick();
    aes_req_ready = 1'b0;
    check("req_valid_low", {127'd0, aes_req_valid}, 128'd0);
    tick();
    aes_rsp_valid = 1'b1; aes_rsp_block = RSPA;
    tick();
    aes_rsp_valid = 1'b0;
    check("tagmask_valid", {127'd0, tagmask_valid}, 128'd1);
    check("tagmask",       tagmask, RSPA);

    // Zero lengths, tagmask_start together with lens_done, then mask timeout
    start = 1'b0;
    tick();
    len_aad_bits = 64'd0; len_pld_bits = 64'd0; start = 1'b1;
    tick();
    check("new_sess_lens_done", {127'd0, lens_done},     128'd0);
    check("new_sess_tmv",       {127'd0, tagmask_valid}, 128'd0);
    check("new_sess_tpx",       tag_pre_xor, 128'd0);
    tick();
    check("zero_gh_valid", {127'd0, gh_valid}, 128'd1);
    check("zero_gh_data",  gh_data, 128'd0);
    gh_ready = 1'b1;
    tick();
    gh_ready = 1'b0;
    ghash_state_valid = 1'b1; ghash_state = GH2;
    tagmask_start = 1'b1; j0 = J0B;
    tick();
    ghash_state_valid = 1'b0; tagmask_start = 1'b0;
    check("zero_lens_done", {127'd0, lens_done}, 128'd1);
    check("zero_tpx",       tag_pre_xor, GH2);
    check("same_cyc_req",   aes_req_block, J0B);
    aes_req_ready = 1'b1;
    tick();
    aes_req_ready = 1'b0;
    repeat (T - 1) begin
      tick();
      check("to_err_early", {127'd0, err}, 128'd0);
    end
    tick();
    check("to_err",      {127'd0, err},           128'd1);
    check("to_no_valid", {127'd0, tagmask_valid}, 128'd0);
    aes_rsp_valid = 1'b1; aes_rsp_block = RSPA;
    tick();
    aes_rsp_valid = 1'b0;
    check("late_rsp_ignored", {127'd0, tagmask_valid}, 128'd0);
    check("err_sticky",       {127'd0, err},           128'd1);

    // Abort in L_SEND, then a lens timeout
    start = 1'b0; phase = 3'd0;
    tick();
    len_aad_bits = 64'h1234; len_pld_bits = 64'h5678; start = 1'b1;
    tick();
    check("start_clears_err", {127'd0, err}, 128'd0);
    phase = 3'd3;
    tick();
    check("ab_gh_data", gh_data, {64'h1234, 64'h5678});
    start = 1'b0; len_aad_bits = 64'hAAAA; len_pld_bits = 64'hBBBB;
    tick();
    start = 1'b1;
    tick();
    check("abort_gh_valid", {127'd0, gh_valid}, 128'd0);
    tick();
    check("resend_gh_valid", {127'd0, gh_valid}, 128'd1);
    check("resend_gh_data",  gh_data, {64'hAAAA, 64'hBBBB});
    gh_ready = 1'b1;
    tick();
    gh_ready = 1'b0;
    repeat (T - 1) tick();
    check("lens_to_err_early", {127'd0, err}, 128'd0);
    tick();
    check("lens_to_err",  {127'd0, err},       128'd1);
    check("lens_to_done", {127'd0, lens_done}, 128'd0);
    tick();
    check("lens_to_no_resend", {127'd0, gh_valid}, 128'd0);

    // Response on the expiry cycle wins
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tagmask_start = 1'b1; j0 = J0C;
    tick();
    tagmask_start = 1'b0; aes_req_ready = 1'b1;
    tick();
    aes_req_ready = 1'b0;
    repeat (T - 1) tick();
    aes_rsp_valid = 1'b1; aes_rsp_block = RSPC;
    tick();
    aes_rsp_valid = 1'b0;
    check("expiry_rsp_valid", {127'd0, tagmask_valid}, 128'd1);
    check("expiry_rsp_err",   {127'd0, err},           128'd0);
    check("expiry_rsp_mask",  tagmask, RSPC);

    phase = 3'd0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_gcm_tag_gen.md
Name: aes_gcm_tag_gen

Overview:
- Finalisation stage directly downstream of the GCM phase controller, with two jobs.
- In the lengths phase (phase == 3) it builds the 128-bit length block and sends it to GHASH. It then captures the final GHASH state as tag_pre_xor and raises lens_done.
- On tagmask_start it sends J0 to the AES core and captures E_K(J0) as tagmask.
- Both results are held as levels so the controller can form the tag in its tag phase.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum wait for a GHASH or AES response before err is raised. Must be at least 2.

Ports:
- clk, input, 1: clock. All logic on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: session start level, same signal the controller sees. Its rising edge starts a new session.
- phase, input, 3: controller phase. 3 = lengths phase.
- len_aad_bits, input, 64: AAD length in bits. Latched on start edge.
- len_pld_bits, input, 64: payload length in bits. Latched on start edge.
- tagmask_start, input, 1: one-cycle request to compute the tag mask.
- j0, input, 128: pre-counter block. Sampled when tagmask_start is high.
- gh_valid, output, 1: length block valid to GHASH.
- gh_ready, input, 1: GHASH accepts the block.
- gh_data, output, 128: length block.
- ghash_state_valid, input, 1: pulse; GHASH has finished absorbing the last block.
- ghash_state, input, 128: GHASH accumulator value.
- aes_req_valid, output, 1: AES request valid.
- aes_req_ready, input, 1: AES core accepts the request.
- aes_req_block, output, 128: AES input block.
- aes_rsp_valid, input, 1: pulse; AES result is present.
- aes_rsp_block, input, 128: AES result.
- lens_done, output, 1: level; length block absorbed and tag_pre_xor captured.
- tag_pre_xor, output, 128: final GHASH value.
- tag_pre_xor_valid, output, 1: level.
- tagmask, output, 128: E_K(J0).
- tagmask_valid, output, 1: level.
- err, output, 1: sticky timeout flag.

Behaviour:
- Reset and start edge:
  - rst clears all outputs and registers to 0 and puts both FSMs in IDLE.
  - start_edge = start & ~start_q, with start_q registered and reset to 0.
  - On start_edge: latch both lengths, set armed=1, clear lens_done, tag_pre_xor(_valid), tagmask(_valid) and err, and force both FSMs to IDLE. This applies even mid-operation: outstanding requests are abandoned and gh_valid/aes_req_valid drop the next cycle.
  - start_edge has priority over every other event in the same cycle.
- Lens FSM states: L_IDLE, L_SEND, L_WAIT, L_DONE.
  - L_IDLE -> L_SEND when phase == 3 and armed. armed clears on this transition, so one length block is sent per session.
  - L_SEND:
    - gh_valid = 1.
    - gh_data = {len_aad_reg, len_pld_reg}, AAD length in bits [127:64].
    - Data is held stable until gh_valid & gh_ready; then -> L_WAIT.
    - Zero lengths still send the all-zero block.
  - L_WAIT: on ghash_state_valid, capture tag_pre_xor = ghash_state, set tag_pre_xor_valid=1 and lens_done=1, -> L_DONE.
  - L_DONE: holds until start_edge or rst.
  - ghash_state_valid outside L_WAIT is ignored.
- Mask FSM states: M_IDLE, M_REQ, M_WAIT, M_DONE.
  - M_IDLE -> M_REQ on tagmask_start; j0 is registered into aes_req_block.
  - M_REQ: aes_req_valid = 1, block held stable until aes_req_valid & aes_req_ready; then -> M_WAIT.
  - M_WAIT: on aes_rsp_valid, tagmask = aes_rsp_block, tagmask_valid=1, -> M_DONE.
  - tagmask_start outside M_IDLE is ignored.
  - aes_rsp_valid outside M_WAIT is ignored.
  - The two FSMs run independently. tagmask_start may arrive in the same cycle that lens_done rises, or any time later.
- Timeout:
  - A counter runs while in L_WAIT or M_WAIT, one counter per FSM. It clears on entry to the wait state.
  - When the count reaches TIMEOUT_CYCLES with no response: set err=1 and move that FSM to IDLE without setting its valid.
  - err is sticky until start_edge or rst.
  - A response in the same cycle as expiry wins; no err is raised.
- Latency:
  - ghash_state_valid -> lens_done / tag_pre_xor_valid high: 1 cycle (registered).
  - aes_rsp_valid -> tagmask_valid high: 1 cycle.
  - phase == 3 -> gh_valid high: 1 cycle.

Test Plan:
- Lengths sequence: start edge with len_aad_bits=0x80, len_pld_bits=0x100, then phase=3 -> gh_valid the next cycle with gh_data = 0x0000000000000080_0000000000000100. Hold gh_ready=0 for 3 cycles and check data stays stable. After the handshake, ghash_state_valid with 0xDEADBEEF...01 -> tag_pre_xor equals that value, and lens_done=1 and tag_pre_xor_valid=1 one cycle later.
- Mask sequence: tagmask_start with j0 = 0x(96-bit IV)_00000001; aes_req_ready=1 -> aes_req_block == j0. aes_rsp_block=0x0123...CDEF -> tagmask equals it and tagmask_valid=1 one cycle later.
- Zero lengths: len_aad_bits = len_pld_bits = 0 -> gh_data = 0 is still sent, and lens_done rises after ghash_state_valid.
- Timeout: TIMEOUT_CYCLES=8, AES request accepted, no response -> err=1 exactly 8 cycles after entering M_WAIT, tagmask_valid stays 0. A later aes_rsp_valid is ignored.
- Abort: start edge while in L_SEND -> gh_valid=0 the next cycle, all valids and err=0. The new lengths are sent on the next phase=3.
- Single-shot and stray inputs: phase held at 3 after lens_done -> no second gh_valid. Stray ghash_state_valid in L_DONE -> tag_pre_xor unchanged.
